// File: rtl/sweep_unit.sv
// Channel-1 frequency sweep: shadow register, periodic sweep timer and overflow/negate-quirk channel disable.
// Each rising clock_128 edge is one sweep tick; write-back goes out on freq_out with a one-cycle freq_we.
module sweep_unit #(
  parameter int FREQ_W   = 11,
  parameter int SHIFT_W  = 3,
  parameter int PERIOD_W = 3
) (
  input  logic                clock_128,
  input  logic                reset,
  input  logic                trigger,
  input  logic [PERIOD_W-1:0] sweep_period,
  input  logic                sweep_negate,
  input  logic [SHIFT_W-1:0]  sweep_shift,
  input  logic [FREQ_W-1:0]   freq_in,
  output logic [FREQ_W-1:0]   freq_out,
  output logic                freq_we,
  output logic                channel_en,
  output logic                sweep_active
);

  localparam int TIMER_W = PERIOD_W + 1;
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] FULL_RELOAD = {1'b1, {PERIOD_W{1'b0}}};

  // Bit FREQ_W of the result flags overflow; subtraction can never set it.
  function automatic logic [FREQ_W:0] sweep_calc(input logic [FREQ_W-1:0] base,
                                                 input logic [SHIFT_W-1:0] shift,
                                                 input logic               negate);
    logic [FREQ_W-1:0] delta;
    delta = base >> shift;
    if (negate) begin
      sweep_calc = {1'b0, base - delta};
    end else begin
      sweep_calc = {1'b0, base} + {1'b0, delta};
    end
  endfunction

  logic [TIMER_W-1:0] timer_r, timer_n;
  logic [FREQ_W-1:0]  shadow_r, shadow_n;
  logic               neg_used_r, neg_used_n;
  logic [FREQ_W-1:0]  freq_out_r, freq_out_n;
  logic               freq_we_r, freq_we_n;
  logic               channel_en_r, channel_en_n;
  logic               sweep_active_r, sweep_active_n;

  logic [TIMER_W-1:0] reload_s;
  logic [FREQ_W:0]    trig_calc_s, tick_calc_s, recheck_s;
  logic               period_nz_s, shift_nz_s, expire_s, do_sweep_s, quirk_s, sweep_kill_s;

  assign period_nz_s = (sweep_period != {PERIOD_W{1'b0}});
  assign shift_nz_s  = (sweep_shift != {SHIFT_W{1'b0}});
  assign reload_s    = period_nz_s ? {1'b0, sweep_period} : FULL_RELOAD;
  assign expire_s    = (timer_r <= TIMER_ONE);
  assign do_sweep_s  = expire_s && sweep_active_r && period_nz_s && channel_en_r;
  assign quirk_s     = neg_used_r && !sweep_negate;
  assign trig_calc_s = sweep_calc(freq_in, sweep_shift, sweep_negate);
  assign tick_calc_s = sweep_calc(shadow_r, sweep_shift, sweep_negate);
  assign recheck_s   = sweep_calc(tick_calc_s[FREQ_W-1:0], sweep_shift, sweep_negate);

  // Next-state logic: trigger load, timer countdown, expiry sweep and quirk disable.
  always_comb begin
    timer_n        = timer_r;
    shadow_n       = shadow_r;
    neg_used_n     = neg_used_r;
    freq_out_n     = freq_out_r;
    freq_we_n      = 1'b0;
    channel_en_n   = channel_en_r;
    sweep_active_n = sweep_active_r;
    sweep_kill_s   = 1'b0;
    if (trigger) begin
      shadow_n       = freq_in;
      timer_n        = reload_s;
      sweep_active_n = period_nz_s || shift_nz_s;
      if (shift_nz_s) begin
        channel_en_n = !trig_calc_s[FREQ_W];
        neg_used_n   = sweep_negate;
      end else begin
        channel_en_n = 1'b1;
        neg_used_n   = 1'b0;
      end
    end else begin
      timer_n = expire_s ? reload_s : (timer_r - TIMER_ONE);
      if (do_sweep_s) begin
        neg_used_n = neg_used_r | sweep_negate;
        if (tick_calc_s[FREQ_W]) begin
          sweep_kill_s = 1'b1;
        end else if (shift_nz_s) begin
          shadow_n     = tick_calc_s[FREQ_W-1:0];
          freq_out_n   = tick_calc_s[FREQ_W-1:0];
          freq_we_n    = 1'b1;
          sweep_kill_s = recheck_s[FREQ_W];
        end else begin
          sweep_kill_s = 1'b0;
        end
      end else begin
        neg_used_n = neg_used_r;
      end
      channel_en_n = channel_en_r && !sweep_kill_s && !quirk_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock_128 or posedge reset) begin
    if (reset) begin
      timer_r        <= {TIMER_W{1'b0}};
      shadow_r       <= {FREQ_W{1'b0}};
      neg_used_r     <= 1'b0;
      freq_out_r     <= {FREQ_W{1'b0}};
      freq_we_r      <= 1'b0;
      channel_en_r   <= 1'b0;
      sweep_active_r <= 1'b0;
    end else begin
      timer_r        <= timer_n;
      shadow_r       <= shadow_n;
      neg_used_r     <= neg_used_n;
      freq_out_r     <= freq_out_n;
      freq_we_r      <= freq_we_n;
      channel_en_r   <= channel_en_n;
      sweep_active_r <= sweep_active_n;
    end
  end

  assign freq_out     = freq_out_r;
  assign freq_we      = freq_we_r;
  assign channel_en   = channel_en_r;
  assign sweep_active = sweep_active_r;

endmodule

// File: tb/tb_sweep_unit.sv
// Bench for sweep_unit: directed scenarios plus random traffic against a behavioural sweep model.
module tb_sweep_unit;

  localparam int LIMIT = 2048;

  logic        clock_128 = 1'b0;
  logic        reset;
  logic        trigger;
  logic [2:0]  sweep_period;
  logic        sweep_negate;
  logic [2:0]  sweep_shift;
  logic [10:0] freq_in;
  logic [10:0] freq_out;
  logic        freq_we, channel_en, sweep_active;

  logic        b_trigger;
  logic [11:0] b_freq_in, b_freq_out;
  logic        b_freq_we, b_channel_en, b_sweep_active;

  int vectors = 0;
  int miscompares = 0;

  int m_timer, m_shadow, m_out;
  bit m_neg, m_we, m_en, m_act;

  always #5 clock_128 = ~clock_128;

  sweep_unit dut (
    .clock_128(clock_128), .reset(reset), .trigger(trigger),
    .sweep_period(sweep_period), .sweep_negate(sweep_negate), .sweep_shift(sweep_shift),
    .freq_in(freq_in), .freq_out(freq_out), .freq_we(freq_we),
    .channel_en(channel_en), .sweep_active(sweep_active)
  );

  sweep_unit #(.FREQ_W(12)) dut_w12 (
    .clock_128(clock_128), .reset(reset), .trigger(b_trigger),
    .sweep_period(3'd1), .sweep_negate(1'b0), .sweep_shift(3'd1),
    .freq_in(b_freq_in), .freq_out(b_freq_out), .freq_we(b_freq_we),
    .channel_en(b_channel_en), .sweep_active(b_sweep_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int calc(input int x);
    int d;
    d = x >> sweep_shift;
    return sweep_negate ? (x - d) : (x + d);
  endfunction

  task automatic model_reset();
    m_timer = 0; m_shadow = 0; m_out = 0;
    m_neg = 0; m_we = 0; m_en = 0; m_act = 0;
  endtask

  // One sweep tick worth of behaviour, from the inputs present before the edge.
  task automatic model_step();
    int reload, r;
    bit expire, kill;
    reload = (sweep_period == 0) ? 8 : int'(sweep_period);
    m_we = 0;
    if (trigger) begin
      m_shadow = freq_in; m_timer = reload; m_neg = 0;
      m_act = (sweep_period != 0) || (sweep_shift != 0);
      if (sweep_shift != 0) begin
        m_en = calc(int'(freq_in)) < LIMIT;
        m_neg = sweep_negate;
      end else begin
        m_en = 1;
      end
    end else begin
      kill = m_neg && !sweep_negate;
      expire = m_timer <= 1;
      if (expire && m_act && sweep_period != 0 && m_en) begin
        r = calc(m_shadow);
        if (r >= LIMIT) kill = 1;
        else if (sweep_shift != 0) begin
          m_shadow = r; m_out = r; m_we = 1;
          if (calc(r) >= LIMIT) kill = 1;
        end
        if (sweep_negate) m_neg = 1;
      end
      if (kill) m_en = 0;
      m_timer = expire ? reload : m_timer - 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".freq_out"}, 32'(freq_out), 32'(m_out));
    chk({tag, ".freq_we"}, 32'(freq_we), 32'(m_we));
    chk({tag, ".channel_en"}, 32'(channel_en), 32'(m_en));
    chk({tag, ".sweep_active"}, 32'(sweep_active), 32'(m_act));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clock_128);
    #1;
    check_model(tag);
  endtask

  task automatic set_in(input bit t, input int f, input int p, input int s, input bit n);
    trigger = t; freq_in = 11'(f); sweep_period = 3'(p); sweep_shift = 3'(s); sweep_negate = n;
  endtask

  initial begin
    reset = 1'b1; b_trigger = 1'b0; b_freq_in = 12'h0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_model("por");
    @(posedge clock_128); #1;
    reset = 1'b0;

    // 1: async reset mid-count, then a plain period-0/shift-0 trigger
    set_in(1, 'h300, 3, 2, 0); step("t1_pre");
    trigger = 0; step("t1_run"); step("t1_run");
    reset = 1'b1; #2;
    model_reset();
    chk("t1_rst_out", 32'(freq_out), 32'h0);
    chk("t1_rst_en", 32'(channel_en), 32'h0);
    chk("t1_rst_act", 32'(sweep_active), 32'h0);
    check_model("t1_rst");
    reset = 1'b0;
    set_in(1, 'h100, 0, 0, 0); step("t1_trig");
    chk("t1_en", 32'(channel_en), 32'h1);
    chk("t1_act", 32'(sweep_active), 32'h0);
    trigger = 0;
    for (int i = 0; i < 10; i++) begin step("t1_idle"); chk("t1_nowe", 32'(freq_we), 32'h0); end

    // 2: add with overflow on the second check; FREQ_W=12 instance run alongside
    set_in(1, 'h400, 1, 1, 0); b_trigger = 1'b1; b_freq_in = 12'h800;
    step("t2_trig");
    chk("t2_en", 32'(channel_en), 32'h1);
    chk("w12_en", 32'(b_channel_en), 32'h1);
    trigger = 0; b_trigger = 1'b0;
    step("t2_exp");
    chk("t2_we", 32'(freq_we), 32'h1);
    chk("t2_out", 32'(freq_out), 32'h600);
    chk("t2_en_off", 32'(channel_en), 32'h0);
    chk("w12_we", 32'(b_freq_we), 32'h1);
    chk("w12_out", 32'(b_freq_out), 32'hC00);
    chk("w12_en_off", 32'(b_channel_en), 32'h0);

    // 3: overflow at trigger time
    set_in(1, 'h7F0, 1, 1, 0); step("t3_trig");
    chk("t3_en", 32'(channel_en), 32'h0);
    trigger = 0;
    for (int i = 0; i < 4; i++) begin step("t3_idle"); chk("t3_nowe", 32'(freq_we), 32'h0); end

    // 4: negate sweep then the negate-clear quirk
    set_in(1, 'h400, 2, 1, 1); step("t4_trig");
    trigger = 0;
    for (int e = 1; e <= 6; e++) begin
      step("t4_run");
      if (e % 2 == 0) begin
        chk("t4_we", 32'(freq_we), 32'h1);
        chk("t4_out", 32'(freq_out), 32'h400 >> (e / 2));
      end else begin
        chk("t4_nowe", 32'(freq_we), 32'h0);
      end
    end
    sweep_negate = 0; step("t4_quirk");
    chk("t4_quirk_en", 32'(channel_en), 32'h0);

    // 5: period 0 / shift 0 never writes; period-0 reload is 8 ticks; shift-0 overflow disables
    set_in(1, 'h500, 0, 0, 0); step("t5_trig");
    trigger = 0;
    for (int i = 0; i < 20; i++) begin
      step("t5_idle");
      chk("t5_nowe", 32'(freq_we), 32'h0);
      chk("t5_en", 32'(channel_en), 32'h1);
    end
    set_in(1, 'h100, 0, 1, 0); step("t5_r8");
    set_in(0, 'h100, 1, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      step("t5_r8run");
      chk("t5_r8we", 32'(freq_we), (i == 8) ? 32'h1 : 32'h0);
    end
    chk("t5_r8out", 32'(freq_out), 32'h180);
    set_in(1, 'h500, 3, 0, 0); step("t5_p3");
    trigger = 0;
    step("t5_p3a"); step("t5_p3b");
    chk("t5_p3_en", 32'(channel_en), 32'h1);
    step("t5_p3c");
    chk("t5_p3_off", 32'(channel_en), 32'h0);
    chk("t5_p3_nowe", 32'(freq_we), 32'h0);

    // 6: trigger coinciding with expiry and a pending quirk
    set_in(1, 'h400, 1, 1, 1); step("t6_pre");
    set_in(1, 'h300, 1, 1, 0); step("t6_trig");
    chk("t6_en", 32'(channel_en), 32'h1);
    chk("t6_nowe", 32'(freq_we), 32'h0);
    trigger = 0; step("t6_after");
    chk("t6_shadow", 32'(freq_out), 32'h480);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      trigger = ($urandom_range(0, 9) == 0);
      freq_in = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 5) == 0) sweep_period = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) sweep_shift = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) sweep_negate = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sweep_unit.md
Name: sweep_unit

Overview:
- Parametrised successor of the channel-1 frequency sweep for the 4-channel sound block.
- Keeps a frequency shadow register and applies trigger-time and periodic sweep calculations on every clock_128 edge (each edge is one sweep tick).
- Frequency write-back uses an explicit freq_out/freq_we strobe to the channel register file; there are no bidirectional ports.
- Covers the full hardware sweep semantics: trigger handling, period-0 reload, a second overflow check after write-back, and the negate-clear disable quirk.

Parameters:
- FREQ_W, 11, width of the channel frequency value.
- SHIFT_W, 3, width of the sweep shift field.
- PERIOD_W, 3, width of the sweep period field. A period of 0 reloads the timer with 2^PERIOD_W.

Ports:
- clock_128  input  1  sweep tick clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high.
- trigger  input  1  one-cycle channel (re)start pulse, synchronous to clock_128.
- sweep_period  input  PERIOD_W  sweep period field (NR10[6:4] equivalent).
- sweep_negate  input  1  1 = subtract, 0 = add.
- sweep_shift  input  SHIFT_W  shift amount.
- freq_in  input  FREQ_W  current channel frequency from the register file.
- freq_out  output  FREQ_W  swept frequency to write back.
- freq_we  output  1  one-cycle write strobe for freq_out.
- channel_en  output  1  channel enable; 0 = disabled by sweep overflow or the negate quirk.
- sweep_active  output  1  internal sweep-enable flag.

Behaviour:
Reset (asynchronous) clears all state to 0: timer, shadow, neg_used, freq_out, freq_we, channel_en, sweep_active.

Arithmetic:
- delta = shadow >> shift.
- Calculation is FREQ_W+1 bits wide.
  - Add mode: sum = shadow + delta.
  - Negate mode: sum = shadow - delta. This cannot underflow; bit FREQ_W is forced to 0.
- ovf(x) = bit FREQ_W of the result.
- Any calculation made with sweep_negate=1 sets neg_used.

reload = (sweep_period==0) ? 2^PERIOD_W : sweep_period. The timer is PERIOD_W+1 bits wide.

Trigger edge (trigger=1):
- shadow <= freq_in; timer <= reload; neg_used <= 0.
- sweep_active <= (sweep_period!=0) || (sweep_shift!=0).
- If sweep_shift!=0, run the calculation on freq_in: channel_en <= !ovf and neg_used <= sweep_negate. Otherwise channel_en <= 1.
- No freq_we on this edge.
- A trigger overrides any simultaneous expiry or quirk event.

Non-trigger edge:
- If timer<=1, the timer expires: timer <= reload.
- Otherwise timer <= timer-1.

Expiry action, only when sweep_active && sweep_period!=0 && channel_en:
- Compute new = calc(shadow).
- If ovf(new): channel_en <= 0 and no write.
- Else if sweep_shift!=0:
  - shadow <= new, freq_out <= new, freq_we <= 1 on this edge only.
  - Second check, combinational in the same edge: calc(new). If it overflows, channel_en <= 0 on the same edge. The second result is not written.
- Else (sweep_shift==0): the overflow check applies but there is no write-back.

Negate quirk: on any non-trigger edge, if neg_used && !sweep_negate, then channel_en <= 0. This check does not depend on expiry.

Other rules:
- freq_we deasserts on the next edge.
- freq_out holds its last value.
- channel_en=0 stays 0 until the next trigger. The sweep timer keeps running, but no writes occur.

Test Plan:
1. Async reset:
   - Stimulus: assert reset mid-count with no clock.
   - Required: all outputs go to 0 immediately.
   - Then: release reset, trigger with freq_in=0x100, shift=0, period=0.
   - Required: channel_en=1, sweep_active=0, no freq_we ever.
2. Add with overflow:
   - Stimulus: trigger freq_in=0x400, period=1, shift=1, add.
   - Required on the trigger edge: channel_en=1.
   - Required on the next edge: freq_we=1, freq_out=0x600, and channel_en=0 on that same edge (second check gives 0x900).
3. Trigger-time overflow:
   - Stimulus: trigger freq_in=0x7F0, shift=1, add.
   - Required: channel_en=0 on the trigger edge; no freq_we afterwards.
4. Negate and quirk:
   - Stimulus: trigger freq_in=0x400, period=2, shift=1, negate.
   - Required: freq_we with freq_out=0x200 on edge 2 after the trigger, 0x100 on edge 4, 0x080 on edge 6.
   - Then: clear sweep_negate.
   - Required: channel_en=0 on the next edge.
5. Period 0 with shift 0:
   - Stimulus: trigger freq_in=0x500, period=0, shift=0.
   - Required: no writes, channel_en stays 1, timer reloads every 8 edges.
   - Then: trigger with period=3, shift=0, freq 0x500.
   - Required: at expiry, 0x500+0x500 overflows, so channel_en=0 and no freq_we.
6. Simultaneous events:
   - Stimulus: trigger on the same edge as an expiry with neg_used=1 and negate cleared.
   - Required: the trigger wins; shadow=freq_in, channel_en=1, no freq_we.
   - Parameter variant: FREQ_W=12, freq_in=0x800, shift=1, period=1, add.
   - Required: write 0xC00, then the second check (0x1200) sets channel_en=0.
